// File: rtl/anti_rebond_pkg.sv
// anti_rebond_pkg: shared state encoding and counter sizing for the button debouncer
package anti_rebond_pkg;

   typedef enum logic [1:0] {STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO} state_t;

   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/anti_rebond_canal.sv
// anti_rebond_canal: one button channel (2-flop synchronizer, debounce FSM, optional auto-repeat via ANTI_REBOND_REPEAT_EN)
module anti_rebond_canal
   import anti_rebond_pkg::*;
#(
   parameter int STABLE_TICKS  = 10,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = cnt_width(STABLE_TICKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   logic          s1, sync;
   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          level_d, rise_d, fall_d, rise_all;

   // two-flop synchronizer for the asynchronous pin
   always_ff @(posedge clk or negedge rst)
      if (!rst) {s1, sync} <= 2'b00;
      else      {s1, sync} <= {btn, s1};

   // state, stable counter and registered outputs
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= STABLE_LO;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         level <= level_d;
         rise  <= rise_all;
         fall  <= fall_d;
      end

   // debounce FSM: a level is accepted only after STABLE_TICKS consecutive ticks
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      level_d = level;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state)
         STABLE_LO:
            if (sync) begin
               state_d = CHECK_HI;
               cnt_d   = '0;
            end
         CHECK_HI:
            if (!sync) state_d = STABLE_LO;
            else if (tick) begin
               if (cnt == CNT_LAST) begin
                  state_d = STABLE_HI;
                  level_d = 1'b1;
                  rise_d  = 1'b1;
               end else cnt_d = cnt + 1'b1;
            end
         STABLE_HI:
            if (!sync) begin
               state_d = CHECK_LO;
               cnt_d   = '0;
            end
         CHECK_LO:
            if (sync) state_d = STABLE_HI;
            else if (tick) begin
               if (cnt == CNT_LAST) begin
                  state_d = STABLE_LO;
                  level_d = 1'b0;
                  fall_d  = 1'b1;
               end else cnt_d = cnt + 1'b1;
            end
         default: state_d = STABLE_LO;
      endcase
   end

`ifdef ANTI_REBOND_REPEAT_EN
   localparam int RW = cnt_width(REPEAT_DELAY);
   localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

   logic [RW-1:0] rep, rep_d;
   logic          hold, rpt;

   // repeat counter register
   always_ff @(posedge clk or negedge rst)
      if (!rst) rep <= '0;
      else      rep <= rep_d;

   // repeat counter runs only while staying in STABLE_HI; any exit clears it
   always_comb begin
      hold  = (state == STABLE_HI) && (state_d == STABLE_HI);
      rpt   = hold && tick && (rep == REP_LAST);
      rep_d = !hold ? '0 : !tick ? rep : rpt ? REP_RELOAD : rep + 1'b1;
   end

   assign rise_all = rise_d | rpt;
`else
   assign rise_all = rise_d;
`endif

endmodule

// File: rtl/anti_rebond.sv
// anti_rebond: N_BTN push-button debouncer with shared sample prescaler (auto-repeat via ANTI_REBOND_REPEAT_EN)
module anti_rebond
   import anti_rebond_pkg::*;
#(
   parameter int N_BTN         = 5,
   parameter int TICK_DIV      = 100000,
   parameter int STABLE_TICKS  = 10,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_rise,
   output logic [N_BTN-1:0] btn_fall
);

   localparam int PW = cnt_width(TICK_DIV - 1);
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pcnt;
   logic          tick;

   assign tick = (pcnt == P_LAST);

   // sample prescaler shared by all channels, wraps after TICK_DIV cycles
   always_ff @(posedge clk or negedge rst)
      if (!rst) pcnt <= '0;
      else      pcnt <= tick ? '0 : pcnt + 1'b1;

   for (genvar i = 0; i < N_BTN; i++) begin : g_canal
      anti_rebond_canal #(
         .STABLE_TICKS (STABLE_TICKS),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_canal (
         .clk  (clk),
         .rst  (rst),
         .tick (tick),
         .btn  (btn_in[i]),
         .level(btn_level[i]),
         .rise (btn_rise[i]),
         .fall (btn_fall[i])
      );
   end

endmodule
